// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, frame header byte and loader state encoding.
//   PC_W        imem address / program counter width
//   OP_W        opcode width (two bytes)
//   HDR         frame header byte
//   ldr_state_t imem_loader FSM states
package cpu_pkg;
    localparam int PC_W = 6;
    localparam int OP_W = 16;
    localparam logic [7:0] HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
        CHECK,
        DONE,
        ERR
    } ldr_state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: byte-serial framed program loader feeding imem, gates CPU run.
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_valid, rx_data  incoming byte stream (transfer on rx_valid && rx_ready)
//   rx_ready           low only in the WRITE cycle
//   wr_en/wr_addr/wr_op  single-cycle imem write of one assembled opcode
//   cpu_run            high once a checksum-verified image is loaded
//   load_err           high after a bad count or checksum, until the next header
//   op_count           opcodes written by the current frame
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::PC_W,
    parameter int OP_W = cpu_pkg::OP_W,
    parameter logic [7:0] HDR = cpu_pkg::HDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [OP_W-1:0]   wr_op,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   op_count
);
    localparam int DEPTH = 2 ** ADDR_W;

    ldr_state_t      state, nxt;
    logic [ADDR_W:0] n;
    logic [7:0]      hi;
    logic [7:0]      xsum;
    logic            xfer;
    logic            last;
    logic            bad_n;

    assign xfer  = rx_valid && rx_ready;
    assign last  = (op_count + 1'b1) == n;
    assign bad_n = (rx_data == 8'd0) || (int'(rx_data) > DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (xfer && rx_data == HDR) ? COUNT : IDLE;
            COUNT:   nxt = xfer ? (bad_n ? ERR : HI) : COUNT;
            HI:      nxt = xfer ? LO : HI;
            LO:      nxt = xfer ? WRITE : LO;
            WRITE:   nxt = last ? CHECK : HI;
            CHECK:   nxt = xfer ? ((rx_data == xsum) ? DONE : ERR) : CHECK;
            DONE:    nxt = (xfer && rx_data == HDR) ? COUNT : DONE;
            ERR:     nxt = (xfer && rx_data == HDR) ? COUNT : ERR;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = state != WRITE;
        wr_en    = state == WRITE;
        cpu_run  = state == DONE;
        load_err = state == ERR;
    end

    // Datapath: every header that starts a frame restarts the counters and checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= '0;
            hi       <= '0;
            xsum     <= '0;
            wr_addr  <= '0;
            wr_op    <= '0;
            op_count <= '0;
        end else if (nxt == COUNT) begin
            xsum     <= '0;
            wr_addr  <= '0;
            op_count <= '0;
        end else begin
            if (state == COUNT && xfer) n <= rx_data[ADDR_W:0];
            if (state == HI && xfer) begin
                hi   <= rx_data;
                xsum <= xsum ^ rx_data;
            end
            if (state == LO && xfer) begin
                wr_op <= {hi, rx_data};
                xsum  <= xsum ^ rx_data;
            end
            if (state == WRITE) begin
                op_count <= op_count + 1'b1;
                // Hold the address on the final word so a 64-word image never wraps it.
                if (!last) wr_addr <= wr_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        rx_valid = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_op;
    logic        cpu_run;
    logic        load_err;
    logic [6:0]  op_count;

    int total = 0;
    int bad = 0;

    logic [5:0]  log_a[256];
    logic [15:0] log_o[256];
    int wtot = 0;
    int rdy_low = 0;
    int rdy_bad = 0;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
        .cpu_run(cpu_run), .load_err(load_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_a[wtot % 256] = wr_addr;
            log_o[wtot % 256] = wr_op;
            wtot = wtot + 1;
        end
        if (!rx_ready) rdy_low = rdy_low + 1;
        if (rx_ready == wr_en) rdy_bad = rdy_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte has transferred.
    task automatic send(input logic [7:0] b);
        int g = 0;
        rx_valid = 1;
        rx_data = b;
        while (!rx_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) check("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_rdy"}, rx_ready, 1);
        check({tag, "_wen"}, wr_en, 0);
        check({tag, "_addr"}, wr_addr, 0);
        check({tag, "_op"}, wr_op, 0);
        check({tag, "_run"}, cpu_run, 0);
        check({tag, "_err"}, load_err, 0);
        check({tag, "_cnt"}, op_count, 0);
    endtask

    int base;
    int rl0, rb0;

    initial begin
        repeat (2) @(negedge clk);
        reset_outputs("rst");
        rst_n = 1;
        @(negedge clk);

        // Good two-word frame
        base = wtot;
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        check("a_run_early", cpu_run, 0);
        send(8'h40);
        rx_valid = 0;
        check("a_run", cpu_run, 1);
        check("a_err", load_err, 0);
        check("a_cnt", op_count, 2);
        check("a_nw", wtot - base, 2);
        check("a_a0", log_a[base % 256], 0);
        check("a_o0", log_o[base % 256], 16'h1234);
        check("a_a1", log_a[(base + 1) % 256], 1);
        check("a_o1", log_o[(base + 1) % 256], 16'hABCD);

        // Bad checksum
        base = wtot;
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h41);
        rx_valid = 0;
        check("b_err", load_err, 1);
        check("b_run", cpu_run, 0);
        check("b_nw", wtot - base, 2);
        check("b_cnt", op_count, 2);

        // Bad counts then a recovering frame
        base = wtot;
        send(8'hA5);
        check("c_clr", load_err, 0);
        send(8'h00);
        check("c_err0", load_err, 1);
        send(8'hA5); send(8'h41);
        check("c_err41", load_err, 1);
        check("c_nw0", wtot - base, 0);
        send(8'hA5);
        check("c_clr2", load_err, 0);
        send(8'h01); send(8'h11); send(8'h22); send(8'h33);
        rx_valid = 0;
        check("c_run", cpu_run, 1);
        check("c_err", load_err, 0);
        check("c_nw", wtot - base, 1);
        check("c_o0", log_o[base % 256], 16'h1122);

        // 64-word frame streamed back to back
        base = wtot;
        send(8'hA5);
        rl0 = rdy_low;
        rb0 = rdy_bad;
        send(8'h40);
        for (int i = 0; i < 64; i++) begin
            send(8'(i));
            send(8'(i) ^ 8'h5A);
        end
        send(8'h00);
        rx_valid = 0;
        check("d_run", cpu_run, 1);
        check("d_cnt", op_count, 64);
        check("d_nw", wtot - base, 64);
        check("d_rlow", rdy_low - rl0, 64);
        check("d_rbad", rdy_bad - rb0, 0);
        begin
            int ea = 0, eo = 0;
            for (int i = 0; i < 64; i++) begin
                if (log_a[(base + i) % 256] !== 6'(i)) ea++;
                if (log_o[(base + i) % 256] !== {8'(i), 8'(i) ^ 8'h5A}) eo++;
            end
            check("d_addrs", ea, 0);
            check("d_ops", eo, 0);
        end

        // Reload from DONE with embedded header bytes as data
        base = wtot;
        send(8'hA5);
        check("e_drop", cpu_run, 0);
        send(8'h01); send(8'hA5); send(8'hA5); send(8'h00);
        rx_valid = 0;
        check("e_run", cpu_run, 1);
        check("e_nw", wtot - base, 1);
        check("e_a0", log_a[base % 256], 0);
        check("e_o0", log_o[base % 256], 16'hA5A5);

        // Reset in the middle of word 3
        send(8'hA5); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
        send(8'h07);
        rx_valid = 0;
        check("f_pre_cnt", op_count, 3);
        #1 rst_n = 0;
        #1 reset_outputs("f_arst");
        @(negedge clk);
        rst_n = 1;
        base = wtot;
        send(8'h12);
        send(8'hA5); send(8'h01); send(8'h56); send(8'h78); send(8'h2E);
        rx_valid = 0;
        check("f_run", cpu_run, 1);
        check("f_nw", wtot - base, 1);
        check("f_o0", log_o[base % 256], 16'h5678);
        check("f_cnt", op_count, 1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader sitting directly upstream of the instruction memory. It accepts a framed program image over a valid/ready byte stream and assembles 16-bit opcodes. It writes each opcode into successive imem addresses starting at 0 and holds the CPU in reset until a complete, checksum-verified image is in place. On success it releases the CPU via `cpu_run`, so the PC starts from address 0 with valid code.

## Interface
- `ADDR_W`, 6: imem address width; depth = 2**ADDR_W = 64 words.
- `OP_W`, 16: opcode width; fixed at two bytes.
- `HDR`, 8'hA5: frame header byte.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  incoming byte.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers when `rx_valid && rx_ready`.
- `wr_en`  out  1  imem write strobe, single-cycle pulse.
- `wr_addr`  out  ADDR_W  imem write address.
- `wr_op`  out  OP_W  opcode to write.
- `cpu_run`  out  1  high = CPU may run; drive CPU `rst_n` with `rst_n & cpu_run`.
- `load_err`  out  1  sticky error flag for the last frame.
- `op_count`  out  ADDR_W+1  number of opcodes written by the current frame.

## Operation
- Frame format: `HDR`, then count byte N (1..64), then 2N opcode bytes (high byte first), then checksum byte = XOR of all 2N opcode bytes.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR.
- IDLE: discard bytes until `HDR`, then go to COUNT. Clear `load_err`, `op_count`, running XOR, and address counter on entry to COUNT.
- COUNT:
  - N == 0 or N > 64: go to ERR.
  - Otherwise latch N and go to HI.
- HI: latch the high byte, fold it into the XOR, go to LO.
- LO:
  - Form `wr_op = {hi, byte}` and fold the byte into the XOR.
  - Go to WRITE.
- WRITE, one cycle:
  - `wr_en` = 1, `rx_ready` = 0.
  - Increment address and `op_count`.
  - Go to CHECK if `op_count` reaches N, else HI.
- CHECK: compare the received byte against the XOR. Match goes to DONE, mismatch goes to ERR.
- DONE: `cpu_run` = 1. Receiving `HDR` drops `cpu_run` the next cycle and goes to COUNT (reload). Other bytes are discarded.
- ERR: `load_err` = 1, `cpu_run` = 0. Receiving `HDR` goes to COUNT. Other bytes are discarded.
- `rx_ready` = 1 in every state except WRITE.
- Address arithmetic: `wr_addr` is ADDR_W bits and never wraps, because N ≤ 64 bounds it. `op_count` is ADDR_W+1 bits, so 64 is representable.

## Timing
- Reset (asynchronous): state IDLE. Outputs after reset:
  - `rx_ready` = 1.
  - `wr_en` = 0, `wr_addr` = 0, `wr_op` = 0.
  - `cpu_run` = 0, `load_err` = 0, `op_count` = 0.
- `wr_en` asserts the cycle after the LO byte transfer.
  - `wr_addr`/`wr_op` are stable during that cycle.
  - `wr_addr` equals the word index (0 for the first opcode).
- `cpu_run` rises the cycle after a matching checksum byte transfers.
- `load_err` rises the cycle after the offending byte transfers.
- One byte transfers per cycle at most. An opcode costs 3 cycles minimum (HI, LO, WRITE).
- A `rx_valid` held during WRITE is not consumed; it transfers on the next cycle.
- `rst_n` asserted mid-frame:
  - Partial writes already issued remain in imem.
  - Loader returns to IDLE with `cpu_run` = 0 and requires a full new frame.
- An `HDR` value inside the opcode or checksum field is data, not a restart.

## Structure
- Shared package `cpu_pkg`: `PC_W` = 6, `OP_W` = 16, `HDR` constant, and the loader state enum `ldr_state_t`.
- Single module, no sub-module. Checksum and counters are inline registers.

## Test plan
- Reset then frame A5 02 12 34 AB CD (checksum 12^34^AB^CD = 40) followed by 40:
  - writes 0x1234@0 and 0xABCD@1;
  - `op_count` = 2;
  - `cpu_run` = 1 one cycle after the 40 byte.
- Same frame with checksum 41: both writes occur, `load_err` = 1, `cpu_run` stays 0.
- Count byte 00 and count byte 41:
  - ERR, no `wr_en`, `load_err` = 1;
  - a following valid frame clears `load_err` and loads normally.
- 64-word frame with `rx_valid` held high continuously:
  - 64 `wr_en` pulses at addresses 0..63;
  - `rx_ready` low exactly in each WRITE cycle;
  - `op_count` = 64.
- In DONE, send A5 01 A5 A5 00:
  - `cpu_run` drops the cycle after the first A5;
  - 0xA5A5 written to address 0, with the embedded A5 bytes treated as data;
  - `cpu_run` rises again.
- Assert `rst_n` low after the HI byte of word 3: outputs return to reset values asynchronously, and the next byte 12 is discarded in IDLE.
